demux_dispatch_ctrl: RTL and testbench

- Sequencing controller for the 1-to-N demultiplexer datapath.
- Accepts one data word at a time on a valid/ready input and holds it in a single-entry register.
- Steers the word to exactly one of NUM_OUT outputs, chosen either by an explicit destination or by a round-robin pointer.
- Enforces a per-transfer timeout so a stalled output cannot block the stream.

---
 rtl/demux_dispatch_ctrl_if.sv | 27 ++
 rtl/demux_dispatch_ctrl.sv | 123 ++++++++++++
 tb/tb_demux_dispatch_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/demux_dispatch_ctrl_if.sv
// Handshake bundle between the upstream source, the dispatch controller and the
// NUM_OUT downstream outputs. The controller connects through the slave modport.
interface demux_dispatch_ctrl_if #(
    parameter int DATA_W  = 8,
    parameter int NUM_OUT = 4
);
    localparam int SEL_W = $clog2(NUM_OUT);

    logic                      mode;
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_W-1:0]         in_data;
    logic [SEL_W-1:0]          in_dest;
    logic [NUM_OUT-1:0]        out_valid;
    logic [NUM_OUT-1:0]        out_ready;
    logic [NUM_OUT*DATA_W-1:0] out_data;

    modport master (
        output mode, in_valid, in_data, in_dest, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  mode, in_valid, in_data, in_dest, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/demux_dispatch_ctrl.sv
// Single-entry dispatch controller steering one word at a time to one of NUM_OUT
// outputs (directed or round-robin), with a send timeout. Optional DISPATCH_STATS_EN adds counters.
module demux_dispatch_ctrl #(
    parameter int DATA_W  = 8,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = $clog2(NUM_OUT),
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux_dispatch_ctrl_if.slave bus,
    output logic                 busy,
    output logic                 drop_pulse,
    output logic [SEL_W-1:0]     rr_ptr
`ifdef DISPATCH_STATS_EN
    ,
    output logic [15:0]          sent_cnt,
    output logic [7:0]           drop_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, SEND, DROP} state_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);

    state_t              state_reg, state_next;
    logic [DATA_W-1:0]   hold_reg;
    logic [SEL_W-1:0]    target_reg;
    logic [SEL_W-1:0]    rr_ptr_reg;
    logic                mode_reg;
    logic [7:0]          wait_reg, wait_next;
    logic                capture;
    logic                complete;
    logic [NUM_OUT-1:0]  valid_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            hold_reg   <= '0;
            target_reg <= '0;
            mode_reg   <= 1'b0;
            rr_ptr_reg <= '0;
            wait_reg   <= '0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            if (capture) begin
                hold_reg   <= bus.in_data;
                target_reg <= bus.mode ? rr_ptr_reg : bus.in_dest;
                mode_reg   <= bus.mode;
            end else if (state_reg == DROP) begin
                hold_reg <= '0;
            end
            // The pointer moves on every finished round-robin transfer, delivered or dropped.
            if ((complete || state_reg == DROP) && mode_reg) begin
                rr_ptr_reg <= rr_ptr_reg + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        wait_next  = wait_reg;
        capture    = 1'b0;
        complete   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    capture    = 1'b1;
                    wait_next  = '0;
                    state_next = SEND;
                end
            end
            SEND: begin
                // A ready on the final waiting edge wins over the timeout.
                if (bus.out_ready[target_reg]) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end else begin
                    wait_next = wait_reg + 8'd1;
                    if (wait_next == TIMEOUT_LIM) begin
                        state_next = DROP;
                    end
                end
            end
            DROP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // rst_n gates in_ready so upstream sees no acceptance while reset is held.
    assign bus.in_ready = rst_n && (state_reg == IDLE);
    assign busy         = (state_reg != IDLE);
    assign drop_pulse   = (state_reg == DROP);
    assign rr_ptr       = rr_ptr_reg;

    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_out
        assign valid_vec[gi] = (state_reg == SEND) && (target_reg == SEL_W'(gi));
        assign bus.out_data[gi*DATA_W +: DATA_W] = valid_vec[gi] ? hold_reg : '0;
    end
    assign bus.out_valid = valid_vec;

`ifdef DISPATCH_STATS_EN
    logic [15:0] sent_cnt_reg;
    logic [7:0]  drop_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sent_cnt_reg <= '0;
            drop_cnt_reg <= '0;
        end else begin
            if (complete && sent_cnt_reg != 16'hFFFF) begin
                sent_cnt_reg <= sent_cnt_reg + 16'd1;
            end
            if (state_reg == DROP && drop_cnt_reg != 8'hFF) begin
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end
        end
    end

    assign sent_cnt = sent_cnt_reg;
    assign drop_cnt = drop_cnt_reg;
`endif
endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Self-checking bench for demux_dispatch_ctrl: directed vector table, async reset
// sequence and randomized transactions against a transaction-level model.
module tb_demux_dispatch_ctrl;
    localparam int DATA_W  = 8;
    localparam int NUM_OUT = 4;
    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       busy;
    logic       drop_pulse;
    logic [1:0] rr_ptr;
`ifdef DISPATCH_STATS_EN
    logic [15:0] sent_cnt;
    logic [7:0]  drop_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int sent_model = 0;
    int drop_model = 0;
    logic [1:0] rr_model;

    demux_dispatch_ctrl_if #(.DATA_W(DATA_W), .NUM_OUT(NUM_OUT)) bus ();

    demux_dispatch_ctrl #(
        .DATA_W(DATA_W), .NUM_OUT(NUM_OUT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .busy(busy),
        .drop_pulse(drop_pulse),
        .rr_ptr(rr_ptr)
`ifdef DISPATCH_STATS_EN
        ,
        .sent_cnt(sent_cnt),
        .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic [1:0] dest;
        logic [7:0] data;
        int         stall;
        logic [1:0] exp_tgt;
        logic       exp_drop;
        logic [1:0] exp_rr;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_stats();
`ifdef DISPATCH_STATS_EN
        check("sent_cnt", 64'(sent_cnt), 64'(sent_model));
        check("drop_cnt", 64'(drop_cnt), 64'(drop_model));
`endif
    endtask

    // One transaction from an IDLE negedge: stall = cycles out_ready[target] stays low.
    task automatic run_txn(input logic m, input logic [1:0] d, input logic [7:0] data,
                           input int stall, input logic [1:0] exp_tgt,
                           input logic exp_drop, input logic [1:0] exp_rr);
        int n;
        logic [31:0] exp_data;
        logic [3:0]  exp_valid;
        logic [3:0]  rdy;
        check("idle_in_ready", 64'(bus.in_ready), 64'd1);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_out_valid", 64'(bus.out_valid), 64'd0);
        bus.mode     = m;
        bus.in_dest  = d;
        bus.in_data  = data;
        bus.in_valid = 1'b1;
        @(negedge clk);
        n = exp_drop ? TIMEOUT : stall + 1;
        exp_data = '0;
        exp_data[exp_tgt*8 +: 8] = data;
        exp_valid = 4'b0001 << exp_tgt;
        for (int i = 0; i < n; i++) begin
            check("send_out_valid", 64'(bus.out_valid), 64'(exp_valid));
            check("send_out_data", 64'(bus.out_data), 64'(exp_data));
            check("send_in_ready", 64'(bus.in_ready), 64'd0);
            check("send_drop", 64'(drop_pulse), 64'd0);
            bus.mode     = 1'($urandom_range(0, 1));
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = 8'($urandom);
            bus.in_dest  = 2'($urandom);
            rdy = 4'($urandom);
            rdy[exp_tgt] = (i >= stall);
            bus.out_ready = rdy;
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = '0;
        if (exp_drop) begin
            check("drop_pulse", 64'(drop_pulse), 64'd1);
            check("drop_out_valid", 64'(bus.out_valid), 64'd0);
            check("drop_in_ready", 64'(bus.in_ready), 64'd0);
            drop_model++;
            @(negedge clk);
        end else begin
            sent_model++;
        end
        check("end_drop_low", 64'(drop_pulse), 64'd0);
        check("rr_ptr", 64'(rr_ptr), 64'(exp_rr));
        check_stats();
    endtask

    initial begin
        logic       m;
        logic [1:0] d;
        logic [1:0] tgt;
        logic       drp;
        int         k;

        //                mode dest data  stall tgt drop rr
        tbl[0]  = '{1'b0, 2'd2, 8'hA5, 0,  2'd2, 1'b0, 2'd0};
        tbl[1]  = '{1'b1, 2'd3, 8'h10, 0,  2'd0, 1'b0, 2'd1};
        tbl[2]  = '{1'b1, 2'd0, 8'h11, 0,  2'd1, 1'b0, 2'd2};
        tbl[3]  = '{1'b1, 2'd0, 8'h12, 0,  2'd2, 1'b0, 2'd3};
        tbl[4]  = '{1'b1, 2'd0, 8'h13, 0,  2'd3, 1'b0, 2'd0};
        tbl[5]  = '{1'b1, 2'd2, 8'h14, 0,  2'd0, 1'b0, 2'd1};
        tbl[6]  = '{1'b0, 2'd1, 8'h55, 5,  2'd1, 1'b0, 2'd1};
        tbl[7]  = '{1'b1, 2'd3, 8'h3C, 15, 2'd1, 1'b1, 2'd2};
        tbl[8]  = '{1'b0, 2'd3, 8'hC3, 14, 2'd3, 1'b0, 2'd2};
        tbl[9]  = '{1'b1, 2'd0, 8'h7E, 14, 2'd2, 1'b0, 2'd3};
        tbl[10] = '{1'b1, 2'd1, 8'h81, 0,  2'd3, 1'b0, 2'd0};

        rst_n         = 1'b0;
        bus.mode      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_dest   = '0;
        bus.out_ready = '0;
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_drop", 64'(drop_pulse), 64'd0);
        check("rst_rr_ptr", 64'(rr_ptr), 64'd0);
        check_stats();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            run_txn(tbl[i].mode, tbl[i].dest, tbl[i].data, tbl[i].stall,
                    tbl[i].exp_tgt, tbl[i].exp_drop, tbl[i].exp_rr);
        end

        // Async reset in the middle of a send: pointer first moved to 1.
        run_txn(1'b1, 2'd2, 8'h99, 0, 2'd0, 1'b0, 2'd1);
        bus.mode     = 1'b0;
        bus.in_dest  = 2'd3;
        bus.in_data  = 8'h77;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("pre_rst_out_valid", 64'(bus.out_valid), 64'h8);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_out_data", 64'(bus.out_data), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("mid_rst_rr_ptr", 64'(rr_ptr), 64'd0);
        check("mid_rst_drop", 64'(drop_pulse), 64'd0);
        @(negedge clk);
        check("held_rst_drop", 64'(drop_pulse), 64'd0);
        sent_model = 0;
        drop_model = 0;
        check_stats();
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);

        // Randomized transactions against the transaction-level model.
        rr_model = 2'd0;
        for (int t = 0; t < 40; t++) begin
            m = 1'($urandom_range(0, 1));
            d = 2'($urandom);
            if ($urandom_range(0, 3) == 0) k = int'($urandom_range(13, 17));
            else                           k = int'($urandom_range(0, 6));
            tgt = m ? rr_model : d;
            drp = (k >= TIMEOUT);
            if (m) rr_model = rr_model + 2'd1;
            run_txn(m, d, 8'($urandom), k, tgt, drp, rr_model);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
